// File: rtl/avl_kc_pkg.sv
// Shared types and helpers for the player-2 keycode Avalon writer.
package avl_kc_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, RDW} kc_state_e;

  localparam logic [3:0] KC_BYTE_EN = 4'b0011;

  // Register layout: keycode in [7:0], game mode in [10:8].
  function automatic logic [31:0] pack_kc(input logic [2:0] mode, input logic [7:0] key);
    return {21'b0, mode, key};
  endfunction

endpackage

// File: rtl/kc_fifo.sv
// Synchronous FIFO with first-word-fall-through head plus a peek at the entry behind it.
// Push must not be asserted when full; pop must not be asserted when empty.
module kc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 11
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic [W-1:0] nxt_dat_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         multi_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  // Entry that becomes head after the current one pops; valid only when multi_o.
  assign nxt_dat_o  = mem_q[rd_ptr_q + AW'(1)];
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign multi_o    = (cnt_q >= (AW+1)'(2));

endmodule

// File: rtl/avl_keycode_writer.sv
// Avalon-MM master writing buffered {game_mode,keycode} updates to one register; 2 cycles accept-to-write, back-to-back when queued.
// Optional write-then-verify readback under AVL_KEYCODE_READBACK_EN; upd_ready drops only while the FIFO is full.
module avl_keycode_writer import avl_kc_pkg::*; #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [11:0] TARGET_ADDR = 12'h000,
  parameter bit          DEDUP       = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [7:0]  keycode_in,
  input  logic [2:0]  game_mode_in,
  output logic        AVL_WRITE,
`ifdef AVL_KEYCODE_READBACK_EN
  output logic        AVL_READ,
  input  logic [31:0] AVL_READDATA,
  output logic        mismatch,
`endif
  output logic        AVL_CS,
  output logic [11:0] AVL_ADDR,
  output logic [31:0] AVL_WRITEDATA,
  output logic [3:0]  AVL_BYTE_EN,
  input  logic        AVL_WAITREQUEST,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  kc_state_e   state_q, state_d;
  logic [10:0] data_q, data_d;
  logic [10:0] last_q;
  logic [7:0]  drop_cnt_q;
  logic [10:0] upd_val, head_dat, nxt_dat;
  logic        full, empty, multi;
  logic        accept, drop, push, pop;
`ifdef AVL_KEYCODE_READBACK_EN
  logic        mismatch_q, mismatch_d;
`endif

  assign upd_val   = {game_mode_in, keycode_in};
  assign upd_ready = !full;
  assign accept    = upd_valid && upd_ready;
  assign drop      = DEDUP && accept && (upd_val == last_q);
  assign push      = accept && !drop;

  kc_fifo #(.DEPTH(FIFO_DEPTH), .W(11)) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push_i    (push),
    .push_dat_i(upd_val),
    .pop_i     (pop),
    .head_dat_o(head_dat),
    .nxt_dat_o (nxt_dat),
    .full_o    (full),
    .empty_o   (empty),
    .multi_o   (multi)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      data_q     <= '0;
      last_q     <= '0;
      drop_cnt_q <= '0;
`ifdef AVL_KEYCODE_READBACK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (accept) last_q <= upd_val;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
`ifdef AVL_KEYCODE_READBACK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef AVL_KEYCODE_READBACK_EN
    mismatch_d = mismatch_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          data_d  = head_dat;
          state_d = WR;
        end
      end
      WR: begin
        if (!AVL_WAITREQUEST) begin
          pop = 1'b1;
`ifdef AVL_KEYCODE_READBACK_EN
          state_d = RD;
`else
          // Head is still the entry being written, so the follow-on comes from behind it or the same-cycle push.
          if (multi) begin
            data_d = nxt_dat;
          end else if (push) begin
            data_d = upd_val;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef AVL_KEYCODE_READBACK_EN
      RD: begin
        if (!AVL_WAITREQUEST) state_d = RDW;
      end
      RDW: begin
        if (AVL_READDATA[10:0] != data_q) mismatch_d = 1'b1;
        if (!empty) begin
          data_d  = head_dat;
          state_d = WR;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign AVL_WRITE     = (state_q == WR);
  assign AVL_ADDR      = (state_q == IDLE) ? 12'h000 : TARGET_ADDR;
  assign AVL_WRITEDATA = (state_q == IDLE) ? 32'h0 : pack_kc(data_q[10:8], data_q[7:0]);
  assign AVL_BYTE_EN   = (state_q == IDLE) ? 4'h0 : KC_BYTE_EN;
  assign busy          = (state_q != IDLE) || !empty;
  assign drop_cnt      = drop_cnt_q;
`ifdef AVL_KEYCODE_READBACK_EN
  assign AVL_READ = (state_q == RD);
  assign AVL_CS   = AVL_WRITE || AVL_READ;
  assign mismatch = mismatch_q;
`else
  assign AVL_CS   = AVL_WRITE;
`endif

endmodule

// File: tb/tb_avl_keycode_writer.sv
// Scoreboarded bench for avl_keycode_writer in its default build.
module tb_avl_keycode_writer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [7:0]  keycode_in = 8'h00;
  logic [2:0]  game_mode_in = 3'd0;
  logic        AVL_WRITE, AVL_CS;
  logic [11:0] AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [3:0]  AVL_BYTE_EN;
  logic        AVL_WAITREQUEST = 1'b0;
  logic        busy;
  logic [7:0]  drop_cnt;

  int          errs = 0;
  int          checks = 0;
  int          n_wr = 0;
  logic [31:0] exp_q[$];
  logic [10:0] m_last = 11'h000;
  logic        p_stall = 1'b0;
  logic [31:0] p_wdata = 32'h0;

  avl_keycode_writer dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .keycode_in     (keycode_in),
    .game_mode_in   (game_mode_in),
    .AVL_WRITE      (AVL_WRITE),
    .AVL_CS         (AVL_CS),
    .AVL_ADDR       (AVL_ADDR),
    .AVL_WRITEDATA  (AVL_WRITEDATA),
    .AVL_BYTE_EN    (AVL_BYTE_EN),
    .AVL_WAITREQUEST(AVL_WAITREQUEST),
    .busy           (busy),
    .drop_cnt       (drop_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Holds upd_valid until the handshake edge, then releases it.
  task automatic send(input logic [7:0] k, input logic [2:0] m);
    int n = 0;
    upd_valid = 1'b1;
    keycode_in = k;
    game_mode_in = m;
    while (!upd_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    check("send_rdy", 32'(upd_ready), 1);
    @(posedge CLK); #1;
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check("idle", 32'(busy), 0);
  endtask

  // Mid-cycle view: inputs and outputs are stable until the next rising edge.
  always @(negedge CLK) begin
    if (RESET) begin
      exp_q.delete();
      m_last = 11'h000;
      p_stall = 1'b0;
    end else begin
      if (upd_valid && upd_ready) begin
        if ({game_mode_in, keycode_in} != m_last)
          exp_q.push_back({21'b0, game_mode_in, keycode_in});
        m_last = {game_mode_in, keycode_in};
      end
      if (AVL_WRITE && p_stall) check("hold_data", AVL_WRITEDATA, p_wdata);
      if (AVL_WRITE && !AVL_WAITREQUEST) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("wdata", AVL_WRITEDATA, exp_q.pop_front());
          check("addr", 32'(AVL_ADDR), 0);
          check("byte_en", 32'(AVL_BYTE_EN), 32'h3);
          check("cs", 32'(AVL_CS), 1);
        end
        n_wr++;
      end
      p_stall = AVL_WRITE && AVL_WAITREQUEST;
      p_wdata = AVL_WRITEDATA;
    end
  end

  initial begin
    int run;
    int cyc;
    int w0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_write", 32'(AVL_WRITE), 0);
    check("rst_cs", 32'(AVL_CS), 0);
    check("rst_addr", 32'(AVL_ADDR), 0);
    check("rst_wdata", AVL_WRITEDATA, 0);
    check("rst_be", 32'(AVL_BYTE_EN), 0);
    check("rst_ready", 32'(upd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Single update, no stall: 2-cycle latency, one write cycle.
    send(8'h1A, 3'd2);
    check("lat1_write", 32'(AVL_WRITE), 0);
    check("lat1_busy", 32'(busy), 1);
    @(posedge CLK); #1;
    check("wr_write", 32'(AVL_WRITE), 1);
    check("wr_wdata", AVL_WRITEDATA, 32'h0000021A);
    check("wr_addr", 32'(AVL_ADDR), 0);
    check("wr_be", 32'(AVL_BYTE_EN), 32'h3);
    @(posedge CLK); #1;
    check("done_write", 32'(AVL_WRITE), 0);
    check("done_busy", 32'(busy), 0);

    // Three stall cycles then completion.
    AVL_WAITREQUEST = 1'b1;
    w0 = n_wr;
    send(8'h07, 3'd0);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (AVL_WRITE) begin
        cyc++;
        if (cyc == 4) AVL_WAITREQUEST = 1'b0;
      end
    end
    check("stall_cycles", cyc, 4);
    check("stall_one_pop", n_wr - w0, 1);
    check("stall_busy", 32'(busy), 0);

    // Fill the FIFO behind a stalled write, then drain back-to-back.
    AVL_WAITREQUEST = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 3'd3);
    check("full_rdy", 32'(upd_ready), 0);
    upd_valid = 1'b1;
    keycode_in = 8'h14;
    game_mode_in = 3'd3;
    @(posedge CLK); #1;
    check("full_hold", 32'(upd_ready), 0);
    check("stall_write", 32'(AVL_WRITE), 1);
    AVL_WAITREQUEST = 1'b0;
    run = 0;
    for (int i = 0; i < 12; i++) begin
      if (AVL_WRITE) run++;
      else if (run > 0) break;
      if (i == 1) check("rdy_after_pop", 32'(upd_ready), 1);
      if (i == 2) upd_valid = 1'b0;
      @(posedge CLK); #1;
    end
    check("b2b_run", run, 5);
    wait_idle();

    // Repeated value collapses to one write.
    w0 = n_wr;
    repeat (3) send(8'h04, 3'd1);
    wait_idle();
    check("dedup_drops", 32'(drop_cnt), 2);
    check("dedup_writes", n_wr - w0, 1);

    // Reset while a write is stalled and another entry is queued.
    AVL_WAITREQUEST = 1'b1;
    send(8'h55, 3'd5);
    send(8'h66, 3'd5);
    @(posedge CLK); #1;
    check("pre_rst_write", 32'(AVL_WRITE), 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_write", 32'(AVL_WRITE), 0);
    check("mid_rst_cs", 32'(AVL_CS), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(upd_ready), 1);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    check("mid_rst_wdata", AVL_WRITEDATA, 0);
    RESET = 1'b0;
    AVL_WAITREQUEST = 1'b0;
    w0 = n_wr;
    repeat (5) @(posedge CLK);
    #1;
    check("post_rst_writes", n_wr - w0, 0);
    check("post_rst_busy", 32'(busy), 0);

    // After reset the last value is zero, so zero updates are all dropped; counter saturates.
    w0 = n_wr;
    repeat (260) send(8'h00, 3'd0);
    wait_idle();
    check("drop_sat", 32'(drop_cnt), 255);
    check("sat_writes", n_wr - w0, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
